// File: rtl/psum_col_drain_pkg.sv
// Shared PE-column constants and psum accumulator helpers.
// Used by the PE column, the psum drain and the ofmap writer.
package psum_col_drain_pkg;

    localparam int unsigned ROWS      = 12;
    localparam int unsigned PSUM_W    = 14;
    localparam int unsigned ACC_W     = 18;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned SHIFT_DEF = 4;

    localparam int unsigned IDX_W   = $clog2(ROWS);
    localparam int unsigned FRAME_W = ROWS * OUT_W;
    localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic acc_t sext_psum(input logic signed [PSUM_W-1:0] s);
        return {{(ACC_W-PSUM_W){s[PSUM_W-1]}}, s};
    endfunction

    // Add one psum to an accumulator, clamping to the signed ACC_W range.
    function automatic acc_t sat_acc_add(input acc_t a, input logic signed [PSUM_W-1:0] s);
        logic [ACC_W:0] sum;
        acc_t           res;
        sum = {a[ACC_W-1], a} + {{(ACC_W+1-PSUM_W){s[PSUM_W-1]}}, s};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            res = sum[ACC_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_col_drain_frame_fifo.sv
// Two-entry frame FIFO; also exposes the head and occupancy as they will be
// after the current edge so the drain can register its outputs.
module psum_frame_fifo
    import psum_col_drain_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  frame_t     push_data_i,
    input  logic       pop_i,
    output frame_t     head_nxt_c,
    output logic [1:0] count_nxt_c,
    output logic       full_o,
    output logic       empty_o
);

    frame_t     mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       full_q;
    logic       empty_q;
    logic       do_pop;
    logic       do_push;

    // A push into a full FIFO only lands when the head leaves the same cycle.
    assign do_pop      = pop_i && !empty_q;
    assign do_push     = push_i && (!full_q || do_pop);
    assign count_nxt_c = count_q + 2'(do_push) - 2'(do_pop);

    always_comb begin
        head_nxt_c = mem_q[rd_ptr_q];
        if ((count_q == 2'd0) || ((count_q == 2'd1) && do_pop)) begin
            head_nxt_c = push_data_i;
        end else if (do_pop) begin
            head_nxt_c = mem_q[rd_ptr_q ^ 1'b1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_q ^ do_push;
            rd_ptr_q <= rd_ptr_q ^ do_pop;
            count_q  <= count_nxt_c;
            full_q   <= (count_nxt_c == 2'd2);
            empty_q  <= (count_nxt_c == 2'd0);
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/psum_col_drain.sv
// PE-column psum receiver: accumulates passes, requantizes the last pass to
// bytes and drains buffered frames as a byte-serial valid/ready stream.
module psum_col_drain
    import psum_col_drain_pkg::*;
#(
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [ROWS*PSUM_W-1:0] psum_in,
    input  logic                   psum_vld,
    input  logic                   first_pass,
    input  logic                   last_pass,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   ovf
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // ReLU, truncating shift and clamp to the unsigned output range.
    function automatic logic [OUT_W-1:0] requant(input acc_t v);
        acc_t             sh;
        logic [OUT_W-1:0] q;
        sh = v >>> SHIFT;
        if (v[ACC_W-1]) begin
            q = '0;
        end else if (sh > acc_t'(OUT_MAX)) begin
            q = '1;
        end else begin
            q = sh[OUT_W-1:0];
        end
        return q;
    endfunction

    acc_t             acc_q [ROWS];
    acc_t             acc_d [ROWS];
    frame_t           new_frame;
    logic             accept;
    logic             push_req;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic             last_row;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    frame_t           head_nxt;
    logic [1:0]       count_nxt;
    logic [OUT_W-1:0] head_byte [ROWS];

    assign accept   = en && psum_vld;
    assign push_req = accept && last_pass;

    // Per-row accumulate and requantize; row 0 sits in the top slice.
    always_comb begin
        logic signed [PSUM_W-1:0] psum_r;
        acc_t                     v;
        psum_r    = '0;
        v         = '0;
        new_frame = '0;
        for (int r = 0; r < ROWS; r++) begin
            psum_r   = psum_in[(ROWS-1-r)*PSUM_W +: PSUM_W];
            v        = first_pass ? sext_psum(psum_r) : sat_acc_add(acc_q[r], psum_r);
            acc_d[r] = accept ? v : acc_q[r];
            new_frame[(ROWS-1-r)*OUT_W +: OUT_W] = requant(v);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= acc_d[r];
            end
        end
    end

    psum_frame_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_req),
        .push_data_i (new_frame),
        .pop_i       (pop),
        .head_nxt_c  (head_nxt),
        .count_nxt_c (count_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign beat     = out_valid_q && out_ready;
    assign last_row = (row_idx_q == IDX_W'(ROWS-1));
    assign pop      = beat && last_row && !fifo_empty;

    // Drain FSM; outputs are computed from post-edge FIFO state so they register.
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = (count_nxt != 2'd0);
        ovf_d       = ovf_q || (push_req && fifo_full && !pop);

        for (int r = 0; r < ROWS; r++) begin
            head_byte[r] = head_nxt[(ROWS-1-r)*OUT_W +: OUT_W];
        end

        if (beat) begin
            row_idx_d = last_row ? '0 : row_idx_q + IDX_W'(1);
        end

        case (state_q)
            ST_IDLE: if (count_nxt != 2'd0) state_d = ST_SEND;
            ST_SEND: if (count_nxt == 2'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_SEND) begin
            out_valid_d = 1'b1;
            out_data_d  = head_byte[row_idx_d];
            out_last_d  = (row_idx_d == IDX_W'(ROWS-1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_psum_col_drain.sv
// Bench for psum_col_drain: table of single-pass frames plus hand sequences,
// all output bytes checked against a scoreboard filled at stimulus time.
module tb_psum_col_drain;
    import psum_col_drain_pkg::*;

    localparam int unsigned PW = ROWS * PSUM_W;

    typedef struct {
        logic [PW-1:0]      psum;
        logic [FRAME_W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [PW-1:0]      psum_in;
    logic               psum_vld;
    logic               first_pass;
    logic               last_pass;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               ovf;

    int    n_cmp = 0;
    int    n_err = 0;
    bit    exp_ovf = 1'b0;
    int    acc_m [ROWS];
    beat_t sb [$];
    vec_t  tbl [4];

    psum_col_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .psum_in    (psum_in),
        .psum_vld   (psum_vld),
        .first_pass (first_pass),
        .last_pass  (last_pass),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat_m(input int x);
        if (x > 131071) return 131071;
        if (x < -131072) return -131072;
        return x;
    endfunction

    function automatic int req_m(input int v);
        int q;
        if (v < 0) return 0;
        q = v / 16;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic logic [PW-1:0] pack3(input int a, input int b, input int c, input int rest);
        logic [PW-1:0] p;
        int            val;
        p = '0;
        for (int r = 0; r < ROWS; r++) begin
            val = (r == 0) ? a : (r == 1) ? b : (r == 2) ? c : rest;
            p[(ROWS-1-r)*PSUM_W +: PSUM_W] = PSUM_W'(val);
        end
        return p;
    endfunction

    function automatic logic [FRAME_W-1:0] exp3(input int e0, input int e1, input int e2, input int rest);
        logic [FRAME_W-1:0] x;
        int                 val;
        x = '0;
        for (int r = 0; r < ROWS; r++) begin
            val = (r == 0) ? e0 : (r == 1) ? e1 : (r == 2) ? e2 : rest;
            x[(ROWS-1-r)*OUT_W +: OUT_W] = OUT_W'(val);
        end
        return x;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one strobe this cycle and update the reference model / scoreboard.
    task automatic strobe(input logic e, input logic f, input logic l, input logic [PW-1:0] p,
                          input bit use_exp, input logic [FRAME_W-1:0] exp);
        logic [FRAME_W-1:0] bytes;
        logic [PSUM_W-1:0]  raw;
        int                 s;
        int                 v;
        int                 occ;
        bit                 popping;
        beat_t              b;
        en         = e;
        psum_vld   = 1'b1;
        first_pass = f;
        last_pass  = l;
        psum_in    = p;
        bytes      = '0;
        if (e) begin
            for (int r = 0; r < ROWS; r++) begin
                raw = p[(ROWS-1-r)*PSUM_W +: PSUM_W];
                s   = int'(raw);
                if (raw[PSUM_W-1]) s = s - 16384;
                v = f ? s : sat_m(acc_m[r] + s);
                acc_m[r] = v;
                bytes[(ROWS-1-r)*OUT_W +: OUT_W] = OUT_W'(req_m(v));
            end
            if (use_exp) bytes = exp;
            if (l) begin
                occ     = (sb.size() + 11) / 12;
                popping = (out_ready == 1'b1) && (sb.size() % 12 == 1);
                if (occ >= 2 && !popping) begin
                    exp_ovf = 1'b1;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        b.data = bytes[(ROWS-1-r)*OUT_W +: OUT_W];
                        b.last = (r == ROWS-1);
                        sb.push_back(b);
                    end
                end
            end
        end
    endtask

    task automatic idle();
        en         = 1'b1;
        psum_vld   = 1'b0;
        first_pass = 1'b0;
        last_pass  = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, output int k);
        k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", sb.size(), k);
            sb.delete();
        end
        chk("drain_valid", out_valid, 0);
        chk("drain_busy", busy, 0);
    endtask

    // Output monitor: a beat is taken at the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got data %0d, expected no output", out_data);
            end else begin
                e = sb.pop_front();
                chk("beat_data", out_data, e.data);
                chk("beat_last", out_last, e.last);
            end
        end
    end

    initial begin
        int   k;
        logic [PW-1:0] p1000;

        tbl[0] = '{pack3(100, -50, 8191, 0),     exp3(6, 0, 255, 0)};
        tbl[1] = '{pack3(15, 16, 17, -1),        exp3(0, 1, 1, 0)};
        tbl[2] = '{pack3(4095, 4096, -8192, 4079), exp3(255, 255, 0, 254)};
        tbl[3] = '{pack3(1000, 1000, 1000, 1000),  exp3(62, 62, 62, 62)};
        p1000  = pack3(1000, 1000, 1000, 1000);

        for (int r = 0; r < ROWS; r++) acc_m[r] = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        psum_in   = '0;
        idle();

        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);

        // Table of single-pass frames, one-cycle latency and 12-cycle drain each.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            strobe(1'b1, 1'b1, 1'b1, tbl[i].psum, 1'b1, tbl[i].exp);
            tick();
            idle();
            chk("latency_valid", out_valid, 1);
            chk("latency_row0", out_data, int'(tbl[i].exp[FRAME_W-1 -: OUT_W]));
            wait_drain(40, k);
            chk("frame_cycles", k, 12);
        end

        // Multi-pass: first, plain add, disabled strobe, last.
        tick();
        strobe(1'b1, 1'b1, 1'b0, p1000, 1'b0, '0);
        tick();
        strobe(1'b1, 1'b0, 1'b0, p1000, 1'b0, '0);
        tick();
        strobe(1'b0, 1'b1, 1'b1, pack3(-8192, 77, 5, 3), 1'b0, '0);
        tick();
        idle();
        chk("multi_no_valid", out_valid, 0);
        chk("multi_no_busy", busy, 0);
        tick();
        strobe(1'b1, 1'b0, 1'b1, p1000, 1'b0, '0);
        tick();
        idle();
        chk("multi_valid", out_valid, 1);
        chk("multi_row0", out_data, 187);
        wait_drain(40, k);

        // Accumulator saturation in both directions over 17 passes.
        tick();
        strobe(1'b1, 1'b1, 1'b0, pack3(8191, -8192, 0, 0), 1'b0, '0);
        for (int i = 0; i < 15; i++) begin
            tick();
            strobe(1'b1, 1'b0, 1'b0, pack3(8191, -8192, 0, 0), 1'b0, '0);
        end
        tick();
        strobe(1'b1, 1'b0, 1'b1, pack3(8191, -8192, 0, 0), 1'b0, '0);
        tick();
        idle();
        chk("sat_row0", out_data, 255);
        wait_drain(40, k);

        // Full FIFO finishing its head while a new frame arrives.
        out_ready = 1'b0;
        tick();
        strobe(1'b1, 1'b1, 1'b1, pack3(300, 400, 500, 600), 1'b0, '0);
        tick();
        strobe(1'b1, 1'b1, 1'b1, pack3(700, 800, 900, 1100), 1'b0, '0);
        tick();
        idle();
        chk("simul_busy", busy, 1);
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 13 && k < 60) begin
            tick();
            k++;
        end
        if (sb.size() != 13) begin
            n_cmp++;
            n_err++;
            $display("FAIL simul_align: got queue depth %0d, expected 13", sb.size());
        end else begin
            strobe(1'b1, 1'b1, 1'b1, pack3(1200, 1300, 1400, 1500), 1'b0, '0);
        end
        tick();
        idle();
        chk("simul_ovf", ovf, 0);
        wait_drain(60, k);
        chk("simul_cycles", k, 24);

        // Backpressure: two frames retained, third dropped, then a gapless stream.
        out_ready = 1'b0;
        tick();
        strobe(1'b1, 1'b1, 1'b1, pack3(160, 320, 480, 640), 1'b0, '0);
        tick();
        strobe(1'b1, 1'b1, 1'b1, pack3(800, 960, 1120, 1280), 1'b0, '0);
        tick();
        strobe(1'b1, 1'b1, 1'b1, pack3(1440, 1600, 1760, 1920), 1'b0, '0);
        tick();
        idle();
        chk("ovf_set", ovf, int'(exp_ovf));
        chk("ovf_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, int'(sb[0].data));
        end
        out_ready = 1'b1;
        wait_drain(60, k);
        chk("stream_cycles", k, 24);
        chk("ovf_sticky", ovf, 1);

        // Reset asserted mid-frame after five bytes have been taken.
        tick();
        strobe(1'b1, 1'b1, 1'b1, pack3(800, 816, 832, 848), 1'b0, '0);
        tick();
        idle();
        k = 0;
        while (sb.size() != 7 && k < 40) begin
            tick();
            k++;
        end
        chk("mid_frame_depth", sb.size(), 7);
        rst_n = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        for (int r = 0; r < ROWS; r++) acc_m[r] = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("after_rst_valid", out_valid, 0);
        chk("after_rst_busy", busy, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
